// File: rtl/a429_wb_arbiter_if.sv
// Bus bundle between two Wishbone requesters, the arbiter and the a429 core slave port.
// Err signals exist only when A429_WB_ARB_TIMEOUT_EN is defined.
interface a429_wb_arbiter_if #(
    parameter int AW = 2,
    parameter int DW = 32
);
    logic          m0_cyc_i;
    logic          m0_stb_i;
    logic          m0_wnr_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o;
    logic          m1_cyc_i;
    logic          m1_stb_i;
    logic          m1_wnr_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o;
    logic          s_cyc_o;
    logic          s_stb_o;
    logic          s_wnr_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
`ifdef A429_WB_ARB_TIMEOUT_EN
    logic          m0_err_o;
    logic          m1_err_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_wnr_i, m0_adr_i, m0_dat_i,
        input  m1_cyc_i, m1_stb_i, m1_wnr_i, m1_adr_i, m1_dat_i,
        input  s_dat_i, s_ack_i,
        output m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o, m0_err_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_wnr_o, s_adr_o, s_dat_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_wnr_i, m0_adr_i, m0_dat_i,
        output m1_cyc_i, m1_stb_i, m1_wnr_i, m1_adr_i, m1_dat_i,
        output s_dat_i, s_ack_i,
        input  m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o, m0_err_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_wnr_o, s_adr_o, s_dat_o
    );
`else
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_wnr_i, m0_adr_i, m0_dat_i,
        input  m1_cyc_i, m1_stb_i, m1_wnr_i, m1_adr_i, m1_dat_i,
        input  s_dat_i, s_ack_i,
        output m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
        output s_cyc_o, s_stb_o, s_wnr_o, s_adr_o, s_dat_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_wnr_i, m0_adr_i, m0_dat_i,
        output m1_cyc_i, m1_stb_i, m1_wnr_i, m1_adr_i, m1_dat_i,
        output s_dat_i, s_ack_i,
        input  m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
        input  s_cyc_o, s_stb_o, s_wnr_o, s_adr_o, s_dat_o
    );
`endif
endinterface

// File: rtl/a429_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with cycle lock in front of the a429 core slave port.
// Optional ack timeout (err pulse + forced release) when A429_WB_ARB_TIMEOUT_EN is defined.
module a429_wb_arbiter #(
    parameter int AW      = 2,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    a429_wb_arbiter_if.slave          bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last;
    logic          w_req0;
    logic          w_req1;
    logic          w_own_cyc;
    logic          w_own_stb;
    logic          w_own_wnr;
    logic [AW-1:0] w_own_adr;
    logic [DW-1:0] w_own_dat;
    logic          w_to_hit;

    assign w_req0 = bus.m0_cyc_i & bus.m0_stb_i;
    assign w_req1 = bus.m1_cyc_i & bus.m1_stb_i;

    // Read data is broadcast; each master qualifies it with its own ack.
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;

    // Select the granted master's bus signals; all zero while idle.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_wnr = 1'b0;
        w_own_adr = {AW{1'b0}};
        w_own_dat = {DW{1'b0}};
        case (r_state)
            ST_GNT0: begin
                w_own_cyc = bus.m0_cyc_i;
                w_own_stb = bus.m0_stb_i;
                w_own_wnr = bus.m0_wnr_i;
                w_own_adr = bus.m0_adr_i;
                w_own_dat = bus.m0_dat_i;
            end
            ST_GNT1: begin
                w_own_cyc = bus.m1_cyc_i;
                w_own_stb = bus.m1_stb_i;
                w_own_wnr = bus.m1_wnr_i;
                w_own_adr = bus.m1_adr_i;
                w_own_dat = bus.m1_dat_i;
            end
            default: begin
                w_own_cyc = 1'b0;
            end
        endcase
    end

`ifdef A429_WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          w_stall;

    assign w_stall  = w_own_cyc & w_own_stb & ~bus.s_ack_i;
    assign w_to_hit = w_stall & (r_cnt == CW'(TIMEOUT - 1));

    // Stalled-strobe counter, cleared while idle (grant entry) and on every ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= {CW{1'b0}};
        end else if ((r_state == ST_IDLE) || bus.s_ack_i) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_stall) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign bus.m0_err_o = (r_state == ST_GNT0) & w_to_hit;
    assign bus.m1_err_o = (r_state == ST_GNT1) & w_to_hit;
`else
    assign w_to_hit = 1'b0;
`endif

    // Next-state and bus outputs; a late ack after the owner drops cyc is swallowed.
    always_comb begin
        w_state_nxt  = r_state;
        bus.s_cyc_o  = w_own_cyc;
        bus.s_stb_o  = w_own_stb;
        bus.s_wnr_o  = w_own_wnr;
        bus.s_adr_o  = w_own_adr;
        bus.s_dat_o  = w_own_dat;
        bus.m0_ack_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && (!w_req1 || r_last)) begin
                    w_state_nxt = ST_GNT0;
                end else if (w_req1) begin
                    w_state_nxt = ST_GNT1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT0: begin
                bus.m0_ack_o = bus.s_ack_i & bus.m0_cyc_i;
                if (!bus.m0_cyc_i || w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GNT0;
                end
            end
            ST_GNT1: begin
                bus.m1_ack_o = bus.s_ack_i & bus.m1_cyc_i;
                if (!bus.m1_cyc_i || w_to_hit) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GNT1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; the round-robin pointer records who released the bus last.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_GNT0) && (w_state_nxt == ST_IDLE)) begin
                r_last <= 1'b0;
            end else if ((r_state == ST_GNT1) && (w_state_nxt == ST_IDLE)) begin
                r_last <= 1'b1;
            end else begin
                r_last <= r_last;
            end
        end
    end

endmodule
